core_sequencer: RTL and testbench
=================================

# core_sequencer

Sequencer that drives the 35-bit `inst` bus of `core`. For each kernel index it runs the weight-stationary flow:

- load kernel words from XMEM into L0, then shift them into the MAC array;
- stream activations from XMEM through L0 into the array;
- drain the OFIFO into PMEM.

It sits between the testbench/host configuration registers and `core`. It is the only writer of `inst` during a run.

## Interface
- `row`, 8: MAC array rows; also the weight-settle wait in cycles
- `col`, 8: MAC array columns; kernel words per kij
- `inst_width`, 35: instruction bus width
- `addr_w`, 11: SRAM address width
- `kij_w`, 4: kernel-index counter width
- `clk`  in  1  single clock, all flops rising-edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `n_kij`  in  kij_w  number of kernel indices; sampled at start
- `len_nij`  in  addr_w  activation words per kij; sampled at start
- `w_base`, `x_base`, `p_base`  in  addr_w each  kernel, activation and psum base addresses; sampled at start
- `ofifo_valid`  in  1  OFIFO has a word at its head (first-word-fall-through)
- `inst`  out  inst_width  instruction word to `core`
- `busy`  out  1  high from the cycle after an accepted start until DONE
- `done`  out  1  one-cycle pulse at run end
- `kij_idx`  out  kij_w  current kernel index

## Operation
- inst layout (decided):
  - [34] acc, driven 0
  - [33] CEN_PMEM, [32] WEN_PMEM, [31:21] A_PMEM
  - [20] CEN_XMEM, [19] WEN_XMEM, [18:8] A_XMEM
  - [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr, [2] execute, [1] load
  - [0] reserved, 0
- CEN and WEN are active-low. Idle inst = 35'h3_0018_0000. The sequencer never drives XMEM WEN=0.
- States: IDLE, W_L0, W_LOAD, W_WAIT, A_L0, EXEC, DRAIN, NEXT, DONE.
- IDLE -> W_L0 on start with n_kij≠0 and len_nij≠0. If start arrives with either at 0: IDLE -> DONE directly, no memory access.
- W_L0:
  - Issue XMEM reads at w_base + kij·col + i, for i = 0..col-1.
  - l0_wr is asserted one cycle after each read issue (SRAM Q latency = 1).
  - The state lasts col+1 cycles; the final cycle is a tail with CEN_XMEM=1 and l0_wr=1.
- W_LOAD: l0_rd=1 and load=1 for col cycles.
- W_WAIT: idle inst for row cycles, so weights settle.
- A_L0: same as W_L0 but at x_base + n, for n = 0..len_nij-1. Lasts len_nij+1 cycles.
- EXEC: l0_rd=1 and execute=1 for len_nij cycles.
- DRAIN:
  - In each cycle with ofifo_valid=1, assert ofifo_rd=1, CEN_PMEM=0, WEN_PMEM=0, A_PMEM = p_base + kij·len_nij + m; then m++.
  - With ofifo_valid=0, drive idle inst and stall. There is no timeout.
  - Exit after len_nij writes.
- NEXT: kij++. Go to W_L0 if kij < n_kij, else DONE.
- DONE: done=1 for one cycle -> IDLE.
- All address arithmetic is modulo 2^addr_w (wraps silently). The kij·col and kij·len_nij products are truncated to addr_w.

## Timing
- Reset (async, immediate):
  - inst = idle value; busy=0, done=0, kij_idx=0; state IDLE; all counters 0.
- Reset mid-run aborts with no done pulse. inst returns to idle in the same cycle reset rises.
- start is accepted in the cycle it is high in IDLE. The first XMEM read issues the next cycle.
- start outside IDLE is ignored. Config inputs are ignored after sampling.
- Outputs are registered. inst changes only on clock edges, except on reset.
- Per-kij cycle count, with no DRAIN stall: (col+1) + col + row + (len_nij+1) + len_nij + len_nij + 1 (NEXT).
- A write to the last PMEM address and the NEXT transition never overlap. DRAIN's final write cycle is followed by NEXT.

## Structure
- Shared package holds:
  - INST_* bit-position constants and the idle-inst constant;
  - the state enum;
  - the CEN/WEN active-low encodings.
- One natural sub-module: `phase_counter`. It is a loadable down-counter with terminal-count flag, instanced for the phase, kij and DRAIN counts.
- inst packing stays in the top-level FSM output register.

## Test plan
- Reset during EXEC (n_kij=2, len_nij=4) -> inst=35'h3_0018_0000 in the same cycle; busy=0; no done pulse; a following start runs normally.
- n_kij=1, len_nij=4, w_base=0, x_base=100, p_base=200, ofifo_valid tied 1:
  - XMEM read addresses 0..7, then 100..103;
  - l0_wr lags each read by one cycle;
  - PMEM writes to 200..203;
  - done after 8+1+8+8+5+4+4+1 cycles = 39, plus 1 for DONE.
- n_kij=3, len_nij=2, p_base=2046: PMEM writes to 2046, 2047, 0, 1, 2, 3 (wrap); kij_idx steps 0→1→2.
- DRAIN with ofifo_valid toggling 1,0,0,1,1,0,1 (len_nij=4): exactly 4 writes, at the valid cycles only, to consecutive addresses; ofifo_rd never high while ofifo_valid=0.
- start with len_nij=0 -> done pulse two cycles later; CEN_XMEM and CEN_PMEM stay 1 throughout. A second start pulse while busy is ignored.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared definitions for core_sequencer: inst bit positions, active-low memory
// encodings, FSM states and the packing of a per-cycle request into an inst word.
package core_sequencer_pkg;

    localparam int INST_W = 35;
    localparam int ADDR_W = 11;

    localparam int INST_ACC        = 34;
    localparam int INST_CEN_PMEM   = 33;
    localparam int INST_WEN_PMEM   = 32;
    localparam int INST_A_PMEM_LSB = 21;
    localparam int INST_CEN_XMEM   = 20;
    localparam int INST_WEN_XMEM   = 19;
    localparam int INST_A_XMEM_LSB = 8;
    localparam int INST_OFIFO_RD   = 7;
    localparam int INST_IFIFO_WR   = 6;
    localparam int INST_IFIFO_RD   = 5;
    localparam int INST_L0_RD      = 4;
    localparam int INST_L0_WR      = 3;
    localparam int INST_EXECUTE    = 2;
    localparam int INST_LOAD       = 1;

    localparam logic MEM_EN  = 1'b0;
    localparam logic MEM_DIS = 1'b1;
    localparam logic MEM_WR  = 1'b0;
    localparam logic MEM_RD  = 1'b1;

    localparam logic [INST_W-1:0] INST_IDLE = 35'h3_0018_0000;

    typedef enum logic [3:0] {
        IDLE, W_L0, W_LOAD, W_WAIT, A_L0, EXEC, DRAIN, NEXT, DONE
    } seq_state_t;

    typedef struct packed {
        logic              pmem_wr;
        logic [ADDR_W-1:0] p_addr;
        logic              xmem_rd;
        logic [ADDR_W-1:0] x_addr;
        logic              ofifo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_req_t;

    // Addresses are only placed on the bus when the matching memory is enabled.
    function automatic logic [INST_W-1:0] pack_inst(input inst_req_t r);
        logic [INST_W-1:0] w;
        w = INST_IDLE;
        if (r.pmem_wr) begin
            w[INST_CEN_PMEM]                    = MEM_EN;
            w[INST_WEN_PMEM]                    = MEM_WR;
            w[INST_A_PMEM_LSB +: ADDR_W]        = r.p_addr;
        end
        if (r.xmem_rd) begin
            w[INST_CEN_XMEM]                    = MEM_EN;
            w[INST_WEN_XMEM]                    = MEM_RD;
            w[INST_A_XMEM_LSB +: ADDR_W]        = r.x_addr;
        end
        w[INST_ACC]      = 1'b0;
        w[INST_OFIFO_RD] = r.ofifo_rd;
        w[INST_IFIFO_WR] = 1'b0;
        w[INST_IFIFO_RD] = 1'b0;
        w[INST_L0_RD]    = r.l0_rd;
        w[INST_L0_WR]    = r.l0_wr;
        w[INST_EXECUTE]  = r.execute;
        w[INST_LOAD]     = r.load;
        return w;
    endfunction

endpackage

// File: rtl/core_sequencer_phase_counter.sv
// Loadable down-counter with terminal-count flag; load wins over decrement.
// Zero latency on tc; the count saturates at zero.
module core_sequencer_phase_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             dec,
    output logic [width-1:0] count,
    output logic             tc
);

    assign tc = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !tc) begin
            count <= count - width'(1);
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Weight-stationary run sequencer driving the core inst bus; inst is registered and
// always describes the current phase cycle. DRAIN stalls while ofifo_valid is low.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int inst_width = INST_W,
    parameter int addr_w     = ADDR_W,
    parameter int kij_w      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [kij_w-1:0]      n_kij,
    input  logic [addr_w-1:0]     len_nij,
    input  logic [addr_w-1:0]     w_base,
    input  logic [addr_w-1:0]     x_base,
    input  logic [addr_w-1:0]     p_base,
    input  logic                  ofifo_valid,
    output logic [inst_width-1:0] inst,
    output logic                  busy,
    output logic                  done,
    output logic [kij_w-1:0]      kij_idx
);

    localparam logic [addr_w-1:0] COL_N = addr_w'(col);
    localparam logic [addr_w-1:0] ROW_N = addr_w'(row);
    localparam logic [addr_w-1:0] A_ONE = addr_w'(1);
    localparam logic [kij_w-1:0]  K_ONE = kij_w'(1);

    seq_state_t state, state_nxt;
    inst_req_t  req;
    logic       act_rd, cfg_load, kij_inc;

    logic              ph_load, ph_dec, ph_tc;
    logic [addr_w-1:0] ph_val, ph_count;
    logic              kij_load, kij_dec, kij_tc;
    logic [kij_w-1:0]  kij_val, kij_count;
    logic              dr_load, dr_dec, dr_tc;
    logic [addr_w-1:0] dr_val, dr_count;

    logic [addr_w-1:0] len_q, x_base_q, w_ptr, x_ptr, p_ptr;
    logic              unused_cnt;

    assign unused_cnt = ^{kij_count, dr_count};

    core_sequencer_phase_counter #(.width(addr_w)) u_phase_cnt (
        .clk(clk), .reset(reset), .load(ph_load), .load_val(ph_val),
        .dec(ph_dec), .count(ph_count), .tc(ph_tc)
    );

    // Counts kernel indices still to run after the current one.
    core_sequencer_phase_counter #(.width(kij_w)) u_kij_cnt (
        .clk(clk), .reset(reset), .load(kij_load), .load_val(kij_val),
        .dec(kij_dec), .count(kij_count), .tc(kij_tc)
    );

    core_sequencer_phase_counter #(.width(addr_w)) u_drain_cnt (
        .clk(clk), .reset(reset), .load(dr_load), .load_val(dr_val),
        .dec(dr_dec), .count(dr_count), .tc(dr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Decides the transition and the instruction for the cycle being entered.
    always_comb begin
        state_nxt = state;
        req       = '0;
        act_rd    = 1'b0;
        cfg_load  = 1'b0;
        kij_inc   = 1'b0;
        ph_load   = 1'b0;
        ph_val    = '0;
        ph_dec    = 1'b0;
        kij_load  = 1'b0;
        kij_val   = '0;
        kij_dec   = 1'b0;
        dr_load   = 1'b0;
        dr_val    = '0;
        dr_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cfg_load = 1'b1;
                    if (n_kij == '0 || len_nij == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = W_L0;
                        ph_load     = 1'b1;
                        ph_val      = COL_N;
                        kij_load    = 1'b1;
                        kij_val     = n_kij - K_ONE;
                        req.xmem_rd = 1'b1;
                        req.x_addr  = w_base;
                    end
                end
            end
            W_L0: begin
                if (ph_tc) begin
                    state_nxt = W_LOAD;
                    ph_load   = 1'b1;
                    ph_val    = COL_N - A_ONE;
                    req.l0_rd = 1'b1;
                    req.load  = 1'b1;
                end else begin
                    ph_dec      = 1'b1;
                    req.l0_wr   = 1'b1;
                    req.xmem_rd = (ph_count != A_ONE);
                    req.x_addr  = w_ptr;
                end
            end
            W_LOAD: begin
                if (ph_tc) begin
                    state_nxt = W_WAIT;
                    ph_load   = 1'b1;
                    ph_val    = ROW_N - A_ONE;
                end else begin
                    ph_dec    = 1'b1;
                    req.l0_rd = 1'b1;
                    req.load  = 1'b1;
                end
            end
            W_WAIT: begin
                if (ph_tc) begin
                    state_nxt   = A_L0;
                    ph_load     = 1'b1;
                    ph_val      = len_q;
                    act_rd      = 1'b1;
                    req.xmem_rd = 1'b1;
                    req.x_addr  = x_base_q;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            A_L0: begin
                if (ph_tc) begin
                    state_nxt   = EXEC;
                    ph_load     = 1'b1;
                    ph_val      = len_q - A_ONE;
                    req.l0_rd   = 1'b1;
                    req.execute = 1'b1;
                end else begin
                    ph_dec      = 1'b1;
                    act_rd      = 1'b1;
                    req.l0_wr   = 1'b1;
                    req.xmem_rd = (ph_count != A_ONE);
                    req.x_addr  = x_ptr;
                end
            end
            EXEC: begin
                if (ph_tc) begin
                    state_nxt = DRAIN;
                    dr_load   = 1'b1;
                    dr_val    = len_q;
                    if (ofifo_valid) begin
                        dr_val       = len_q - A_ONE;
                        req.pmem_wr  = 1'b1;
                        req.ofifo_rd = 1'b1;
                        req.p_addr   = p_ptr;
                    end
                end else begin
                    ph_dec      = 1'b1;
                    req.l0_rd   = 1'b1;
                    req.execute = 1'b1;
                end
            end
            DRAIN: begin
                if (dr_tc) begin
                    state_nxt = NEXT;
                end else if (ofifo_valid) begin
                    dr_dec       = 1'b1;
                    req.pmem_wr  = 1'b1;
                    req.ofifo_rd = 1'b1;
                    req.p_addr   = p_ptr;
                end
            end
            NEXT: begin
                kij_inc = 1'b1;
                if (kij_tc) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt   = W_L0;
                    kij_dec     = 1'b1;
                    ph_load     = 1'b1;
                    ph_val      = COL_N;
                    req.xmem_rd = 1'b1;
                    req.x_addr  = w_ptr;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weight and psum pointers run on across kernel indices, which gives the
    // base + kij*stride addressing modulo 2^addr_w without a multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst     <= INST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            kij_idx  <= '0;
            len_q    <= '0;
            x_base_q <= '0;
            w_ptr    <= '0;
            x_ptr    <= '0;
            p_ptr    <= '0;
        end else begin
            inst <= pack_inst(req);
            busy <= (state_nxt != IDLE);
            done <= (state == DONE);
            if (cfg_load) begin
                len_q    <= len_nij;
                x_base_q <= x_base;
                kij_idx  <= '0;
            end else if (kij_inc) begin
                kij_idx <= kij_idx + K_ONE;
            end
            if (req.xmem_rd) begin
                if (act_rd) begin
                    x_ptr <= req.x_addr + A_ONE;
                end else begin
                    w_ptr <= req.x_addr + A_ONE;
                end
            end
            if (cfg_load) begin
                p_ptr <= p_base;
            end else if (req.pmem_wr) begin
                p_ptr <= p_ptr + A_ONE;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: builds the expected per-cycle inst/busy/done/kij_idx
// trace from the phase rules and compares it against the DUT cycle by cycle.
module tb_core_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int KW  = 4;
    localparam int IW  = 35;
    localparam int NV  = 8192;
    localparam logic [IW-1:0] IDLE_W = 35'h3_0018_0000;

    localparam int C_OFRD = 8'h80;
    localparam int C_L0RD = 8'h10;
    localparam int C_L0WR = 8'h08;
    localparam int C_EXE  = 8'h04;
    localparam int C_LD   = 8'h02;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] n_kij;
    logic [AW-1:0] len_nij, w_base, x_base, p_base;
    logic          ofifo_valid;
    logic [IW-1:0] inst;
    logic          busy, done;
    logic [KW-1:0] kij_idx;

    int checks = 0;
    int errors = 0;

    bit            vld[NV];
    logic [IW-1:0] e_inst[$];
    bit            e_busy[$];
    bit            e_done[$];
    logic [KW-1:0] e_kij[$];

    always #5 clk = ~clk;

    core_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .n_kij(n_kij), .len_nij(len_nij),
        .w_base(w_base), .x_base(x_base), .p_base(p_base), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
    );

    function automatic bit vld_at(input int t);
        return (t < NV) ? vld[t] : 1'b1;
    endfunction

    function automatic logic [IW-1:0] mk(input bit xrd, input int xa, input bit pwr,
                                         input int pa, input int ctl);
        logic [IW-1:0] w;
        logic [AW-1:0] a;
        w = IDLE_W;
        if (xrd) begin
            a      = AW'(xa);
            w[20]  = 1'b0;
            w[18:8] = a;
        end
        if (pwr) begin
            a        = AW'(pa);
            w[33]    = 1'b0;
            w[32]    = 1'b0;
            w[31:21] = a;
        end
        w[7:0] = 8'(ctl);
        return w;
    endfunction

    task automatic push(input logic [IW-1:0] w, input bit b, input bit d, input int k);
        e_inst.push_back(w);
        e_busy.push_back(b);
        e_done.push_back(d);
        e_kij.push_back(KW'(k));
    endtask

    // Entry i of the trace is the expected output in cycle i+1 after the start edge;
    // vld[t] is the ofifo_valid level present at the edge ending cycle t.
    task automatic build(input int n, input int len, input int wb, input int xb, input int pb);
        int wr;
        int kf;
        e_inst.delete(); e_busy.delete(); e_done.delete(); e_kij.delete();
        kf = 0;
        if (n == 0 || len == 0) begin
            push(IDLE_W, 1, 0, 0);
        end else begin
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i <= COL; i++)
                    push(mk(i < COL, wb + k*COL + i, 0, 0, (i > 0) ? C_L0WR : 0), 1, 0, k);
                for (int i = 0; i < COL; i++) push(mk(0, 0, 0, 0, C_L0RD | C_LD), 1, 0, k);
                for (int i = 0; i < ROW; i++) push(IDLE_W, 1, 0, k);
                for (int i = 0; i <= len; i++)
                    push(mk(i < len, xb + i, 0, 0, (i > 0) ? C_L0WR : 0), 1, 0, k);
                for (int i = 0; i < len; i++) push(mk(0, 0, 0, 0, C_L0RD | C_EXE), 1, 0, k);
                wr = 0;
                while (wr < len) begin
                    if (vld_at(e_inst.size())) begin
                        push(mk(0, 0, 1, pb + k*len + wr, C_OFRD), 1, 0, k);
                        wr++;
                    end else begin
                        push(IDLE_W, 1, 0, k);
                    end
                end
                push(IDLE_W, 1, 0, k);
            end
            push(IDLE_W, 1, 0, n);
            kf = n;
        end
        push(IDLE_W, 0, 1, kf);
        push(IDLE_W, 0, 0, kf);
        push(IDLE_W, 0, 0, kf);
    endtask

    task automatic run(input string name, input int n, input int len, input int wb,
                       input int xb, input int pb, input int extra_start, output int nwr);
        nwr = 0;
        build(n, len, wb, xb, pb);
        @(negedge clk);
        start = 1'b1; n_kij = KW'(n); len_nij = AW'(len);
        w_base = AW'(wb); x_base = AW'(xb); p_base = AW'(pb);
        ofifo_valid = vld_at(0);
        for (int c = 1; c <= e_inst.size(); c++) begin
            @(negedge clk);
            start       = (c == extra_start);
            n_kij       = KW'($urandom);
            len_nij     = AW'($urandom);
            w_base      = AW'($urandom);
            x_base      = AW'($urandom);
            p_base      = AW'($urandom);
            ofifo_valid = vld_at(c);
            checks += 5;
            if (inst !== e_inst[c-1]) begin
                errors++;
                $display("FAIL %s inst cycle %0d: got %h expected %h", name, c, inst, e_inst[c-1]);
            end
            if (busy !== e_busy[c-1]) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, e_busy[c-1]);
            end
            if (done !== e_done[c-1]) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, e_done[c-1]);
            end
            if (kij_idx !== e_kij[c-1]) begin
                errors++;
                $display("FAIL %s kij_idx cycle %0d: got %0d expected %0d", name, c, kij_idx, e_kij[c-1]);
            end
            if (inst[7] === 1'b1 && !vld_at(c-1)) begin
                errors++;
                $display("FAIL %s ofifo_rd cycle %0d: got 1 with ofifo_valid 0 expected 0", name, c);
            end
            if (inst[7] === 1'b1) nwr++;
        end
        start = 1'b0;
    endtask

    task automatic fill_const(input bit v);
        for (int i = 0; i < NV; i++) vld[i] = v;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (inst !== IDLE_W) begin errors++; $display("FAIL reset inst: got %h expected %h", inst, IDLE_W); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        if (kij_idx !== '0) begin errors++; $display("FAIL reset kij_idx: got %0d expected 0", kij_idx); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (inst !== IDLE_W || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset idle: got inst %h busy %b expected %h 0", inst, busy, IDLE_W);
        end
    endtask

    task automatic test_single_kij();
        int nwr;
        fill_const(1);
        run("single_kij", 1, 4, 0, 100, 200, 5, nwr);
        checks++;
        if (nwr != 4) begin errors++; $display("FAIL single_kij writes: got %0d expected 4", nwr); end
    endtask

    task automatic test_reset_mid_run();
        fill_const(1);
        @(negedge clk);
        start = 1'b1; n_kij = 4'd2; len_nij = 11'd4; w_base = 11'd0; x_base = 11'd50; p_base = 11'd300;
        ofifo_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        checks++;
        if (inst !== mk(0, 0, 0, 0, C_L0RD | C_EXE)) begin
            errors++;
            $display("FAIL midrun exec inst: got %h expected %h", inst, mk(0, 0, 0, 0, C_L0RD | C_EXE));
        end
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (inst !== IDLE_W) begin errors++; $display("FAIL midrun reset inst: got %h expected %h", inst, IDLE_W); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrun reset busy: got %b expected 0", busy); end
        if (kij_idx !== '0) begin errors++; $display("FAIL midrun reset kij_idx: got %0d expected 0", kij_idx); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) begin
                errors++;
                $display("FAIL midrun aborted cycle %0d: got done %b busy %b inst %h expected 0 0 %h",
                         c, done, busy, inst, IDLE_W);
            end
        end
    endtask

    task automatic test_wrap();
        int nwr;
        fill_const(1);
        run("wrap", 3, 2, 2040, 2047, 2046, 0, nwr);
        checks++;
        if (nwr != 6) begin errors++; $display("FAIL wrap writes: got %0d expected 6", nwr); end
    endtask

    task automatic test_drain_stall();
        int nwr;
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int d0;
        fill_const(0);
        d0 = (COL + 1) + COL + ROW + (4 + 1) + 4;
        for (int j = 0; j < 7; j++) vld[d0 + j] = pat[j];
        run("drain_stall", 1, 4, 10, 20, 30, 0, nwr);
        checks++;
        if (nwr != 4) begin errors++; $display("FAIL drain_stall writes: got %0d expected 4", nwr); end
    endtask

    task automatic test_zero_len();
        int nwr;
        fill_const(1);
        run("zero_len", 2, 0, 5, 6, 7, 1, nwr);
        run("zero_kij", 0, 5, 5, 6, 7, 1, nwr);
        checks++;
        if (nwr != 0) begin errors++; $display("FAIL zero_kij writes: got %0d expected 0", nwr); end
    endtask

    task automatic test_random();
        int nwr;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NV; i++) vld[i] = bit'($urandom_range(0, 1));
            run("random", int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                int'($urandom_range(0, 2047)), int'($urandom_range(2, 12)), nwr);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
        n_kij = '0; len_nij = '0; w_base = '0; x_base = '0; p_base = '0;
        test_reset();
        test_single_kij();
        test_reset_mid_run();
        test_single_kij();
        test_wrap();
        test_drain_stall();
        test_zero_len();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
